// File: rtl/registrador_pkg.sv
// Shared operation encoding for the universal register, its next-state logic and benches.
package registrador_pkg;

   typedef enum logic [2:0] {
      HOLD = 3'b000,
      LOAD = 3'b001,
      SHL  = 3'b010,
      SHR  = 3'b011,
      ROL  = 3'b100,
      ROR  = 3'b101,
      INC  = 3'b110,
      DEC  = 3'b111
   } modo_t;

endpackage

// File: rtl/registrador_next.sv
// Combinational next-state function of the universal register: computes q/carry for one mode.
module registrador_next
   import registrador_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter bit          SATURATE = 1'b0
) (
   input  logic [WIDTH-1:0] q,
   input  logic             carry,
   input  modo_t            mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q_next,
   output logic             carry_next
);

   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   // Bit WIDTH of the extended sum is the carry; of the extended difference, the borrow.
   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   assign sum  = {1'b0, q} + ONE;
   assign diff = {1'b0, q} - ONE;

   always_comb begin
      q_next     = q;
      carry_next = carry;
      // Unknown or unlisted encodings fall through to the hold defaults.
      case (mode)
         LOAD: begin
            q_next     = d;
            carry_next = 1'b0;
         end
         SHL: begin
            q_next     = {q[WIDTH-2:0], sin_r};
            carry_next = q[WIDTH-1];
         end
         SHR: begin
            q_next     = {sin_l, q[WIDTH-1:1]};
            carry_next = q[0];
         end
         ROL: begin
            q_next     = {q[WIDTH-2:0], q[WIDTH-1]};
            carry_next = q[WIDTH-1];
         end
         ROR: begin
            q_next     = {q[0], q[WIDTH-1:1]};
            carry_next = q[0];
         end
         INC: begin
            carry_next = sum[WIDTH];
            if (!(SATURATE && sum[WIDTH])) q_next = sum[WIDTH-1:0];
         end
         DEC: begin
            carry_next = diff[WIDTH];
            if (!(SATURATE && diff[WIDTH])) q_next = diff[WIDTH-1:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/registrador_universal.sv
// WIDTH-bit universal register: load, shift, rotate, inc/dec with carry/zero flags.
module registrador_universal
   import registrador_pkg::*;
#(
   parameter int unsigned      WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             carry,
   output logic             zero
);

   logic [WIDTH-1:0] q_next;
   logic             carry_next;

   registrador_next #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
   ) u_next (
      .q          (q),
      .carry      (carry),
      .mode       (modo_t'(mode)),
      .d          (d),
      .sin_l      (sin_l),
      .sin_r      (sin_r),
      .q_next     (q_next),
      .carry_next (carry_next)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         q     <= RESET_VAL;
         carry <= 1'b0;
      end else if (en) begin
         q     <= q_next;
         carry <= carry_next;
      end
   end

   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];
   assign zero   = (q == '0);

endmodule

// File: tb/tb_registrador_universal.sv
// Bench for registrador_universal: three single instances plus a two-stage chain vs. arithmetic model.
module tb_registrador_universal;
   import registrador_pkg::*;

   logic       clk = 1'b0;
   logic       rst, en, sin_l, sin_r;
   logic [2:0] mode;
   logic [3:0] d, d2;

   logic [3:0] qv  [5];
   logic       cv  [5];
   logic       zv  [5];
   logic       slv [5];
   logic       srv [5];

   int mq [5];
   int mc [5];
   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   // u0: wrap, reset 0; u1: saturate; u2: reset 1001; u3 -> u4: chained shift
   registrador_universal #(.WIDTH(4), .RESET_VAL(4'b0000), .SATURATE(1'b0)) u0 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
      .q(qv[0]), .sout_l(slv[0]), .sout_r(srv[0]), .carry(cv[0]), .zero(zv[0]));
   registrador_universal #(.WIDTH(4), .RESET_VAL(4'b0000), .SATURATE(1'b1)) u1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
      .q(qv[1]), .sout_l(slv[1]), .sout_r(srv[1]), .carry(cv[1]), .zero(zv[1]));
   registrador_universal #(.WIDTH(4), .RESET_VAL(4'b1001), .SATURATE(1'b0)) u2 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
      .q(qv[2]), .sout_l(slv[2]), .sout_r(srv[2]), .carry(cv[2]), .zero(zv[2]));
   registrador_universal #(.WIDTH(4), .RESET_VAL(4'b0000), .SATURATE(1'b0)) ua (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
      .q(qv[3]), .sout_l(slv[3]), .sout_r(srv[3]), .carry(cv[3]), .zero(zv[3]));
   registrador_universal #(.WIDTH(4), .RESET_VAL(4'b0000), .SATURATE(1'b0)) ub (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d2), .sin_l(sin_l), .sin_r(slv[3]),
      .q(qv[4]), .sout_l(slv[4]), .sout_r(srv[4]), .carry(cv[4]), .zero(zv[4]));

   // Reference behaviour for a 4-bit register, expressed as integer arithmetic.
   function automatic void model(input bit sat, input int q, input int c, input logic [2:0] m,
                                 input int dv, input int sl, input int sr,
                                 output int qn, output int cn);
      qn = q;
      cn = c;
      case (m)
         3'd1: begin qn = dv;                      cn = 0;      end
         3'd2: begin qn = (q * 2 + sr) % 16;       cn = q / 8;  end
         3'd3: begin qn = sl * 8 + q / 2;          cn = q % 2;  end
         3'd4: begin qn = (q * 2) % 16 + q / 8;    cn = q / 8;  end
         3'd5: begin qn = (q % 2) * 8 + q / 2;     cn = q % 2;  end
         3'd6: begin
            if (q == 15) begin qn = sat ? 15 : 0; cn = 1; end
            else         begin qn = q + 1;        cn = 0; end
         end
         3'd7: begin
            if (q == 0) begin qn = sat ? 0 : 15; cn = 1; end
            else        begin qn = q - 1;        cn = 0; end
         end
         default: ;
      endcase
   endfunction

   task automatic step(input logic r, input logic e, input logic [2:0] m,
                       input logic [3:0] dv, input logic [3:0] dv2,
                       input logic sl, input logic sr);
      int nq [5];
      int nc [5];
      rst = r; en = e; mode = m; d = dv; d2 = dv2; sin_l = sl; sin_r = sr;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         if (!r) begin
            nq[i] = (i == 2) ? 9 : 0;
            nc[i] = 0;
         end else if (e) begin
            model(i == 1, mq[i], mc[i], m, (i == 4) ? int'(dv2) : int'(dv), int'(sl),
                  (i == 4) ? mq[3] / 8 : int'(sr), nq[i], nc[i]);
         end else begin
            nq[i] = mq[i];
            nc[i] = mc[i];
         end
      end
      mq = nq;
      mc = nc;
      @(negedge clk);
   endtask

   task automatic test_reset;
      step(1'b0, 1'b1, LOAD, 4'b1010, 4'b1010, 1'b0, 1'b0);
      if (qv[0] !== 4'b0000 || cv[0] !== 1'b0 || zv[0] !== 1'b1) begin
         $display("FAIL reset q=%b c=%b z=%b exp 0000/0/1", qv[0], cv[0], zv[0]); fails++;
      end
      checks++;
      if (qv[2] !== 4'b1001 || zv[2] !== 1'b0) begin
         $display("FAIL reset_val q=%b z=%b exp 1001/0", qv[2], zv[2]); fails++;
      end
      checks++;
      step(1'b1, 1'b1, LOAD, 4'b1010, 4'b0000, 1'b0, 1'b0);
      if (qv[0] !== 4'b1010 || cv[0] !== 1'b0 || zv[0] !== 1'b0) begin
         $display("FAIL load q=%b c=%b z=%b exp 1010/0/0", qv[0], cv[0], zv[0]); fails++;
      end
      checks++;
   endtask

   task automatic test_shift_rotate;
      logic [3:0] exp_q [4];
      logic       exp_c [4];
      logic [2:0] ops   [4];
      exp_q = '{4'b0110, 4'b1011, 4'b1101, 4'b1011};
      exp_c = '{1'b1, 1'b0, 1'b1, 1'b1};
      ops   = '{SHL, SHR, ROR, ROL};
      step(1'b1, 1'b1, LOAD, 4'b1011, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, ops[i], 4'b0000, 4'b0000, 1'b1, 1'b0);
         if (qv[0] !== exp_q[i] || cv[0] !== exp_c[i] ||
             slv[0] !== exp_q[i][3] || srv[0] !== exp_q[i][0]) begin
            $display("FAIL shift[%0d] q=%b c=%b sl=%b sr=%b exp q=%b c=%b",
                     i, qv[0], cv[0], slv[0], srv[0], exp_q[i], exp_c[i]); fails++;
         end
         checks++;
      end
   endtask

   task automatic test_wrap;
      step(1'b1, 1'b1, LOAD, 4'b1110, 4'b0000, 1'b0, 1'b0);
      step(1'b1, 1'b1, INC, 4'b0000, 4'b0000, 1'b0, 1'b0);
      if (qv[0] !== 4'b1111 || cv[0] !== 1'b0) begin
         $display("FAIL inc1 q=%b c=%b exp 1111/0", qv[0], cv[0]); fails++;
      end
      checks++;
      step(1'b1, 1'b1, INC, 4'b0000, 4'b0000, 1'b0, 1'b0);
      if (qv[0] !== 4'b0000 || cv[0] !== 1'b1 || zv[0] !== 1'b1) begin
         $display("FAIL inc_wrap q=%b c=%b z=%b exp 0000/1/1", qv[0], cv[0], zv[0]); fails++;
      end
      checks++;
      step(1'b1, 1'b1, DEC, 4'b0000, 4'b0000, 1'b0, 1'b0);
      if (qv[0] !== 4'b1111 || cv[0] !== 1'b1) begin
         $display("FAIL dec_wrap q=%b c=%b exp 1111/1", qv[0], cv[0]); fails++;
      end
      checks++;
   endtask

   task automatic test_saturate;
      step(1'b1, 1'b1, LOAD, 4'b1111, 4'b0000, 1'b0, 1'b0);
      step(1'b1, 1'b1, INC, 4'b0000, 4'b0000, 1'b0, 1'b0);
      if (qv[1] !== 4'b1111 || cv[1] !== 1'b1) begin
         $display("FAIL sat_inc q=%b c=%b exp 1111/1", qv[1], cv[1]); fails++;
      end
      checks++;
      step(1'b1, 1'b1, LOAD, 4'b0001, 4'b0000, 1'b0, 1'b0);
      step(1'b1, 1'b1, DEC, 4'b0000, 4'b0000, 1'b0, 1'b0);
      if (qv[1] !== 4'b0000 || cv[1] !== 1'b0 || zv[1] !== 1'b1) begin
         $display("FAIL sat_dec1 q=%b c=%b z=%b exp 0000/0/1", qv[1], cv[1], zv[1]); fails++;
      end
      checks++;
      step(1'b1, 1'b1, DEC, 4'b0000, 4'b0000, 1'b0, 1'b0);
      if (qv[1] !== 4'b0000 || cv[1] !== 1'b1) begin
         $display("FAIL sat_dec0 q=%b c=%b exp 0000/1", qv[1], cv[1]); fails++;
      end
      checks++;
   endtask

   task automatic test_hold_reset;
      // 1011 >> 1 with sin_l=0 leaves 0101 and carry=1, so a held carry is distinguishable.
      step(1'b1, 1'b1, LOAD, 4'b1011, 4'b0000, 1'b0, 1'b0);
      step(1'b1, 1'b1, SHR, 4'b0000, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, INC, 4'b1111, 4'b1111, 1'b1, 1'b1);
         if (qv[0] !== 4'b0101 || cv[0] !== 1'b1) begin
            $display("FAIL hold[%0d] q=%b c=%b exp 0101/1", i, qv[0], cv[0]); fails++;
         end
         checks++;
      end
      step(1'b0, 1'b1, SHL, 4'b0000, 4'b0000, 1'b1, 1'b1);
      if (qv[0] !== 4'b0000 || cv[0] !== 1'b0 || qv[2] !== 4'b1001 || cv[2] !== 1'b0) begin
         $display("FAIL mid_reset q0=%b c0=%b q2=%b c2=%b exp 0000/0 1001/0",
                  qv[0], cv[0], qv[2], cv[2]); fails++;
      end
      checks++;
   endtask

   task automatic test_chain;
      step(1'b1, 1'b1, LOAD, 4'b1001, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, SHL, 4'b0000, 4'b0000, 1'b0, 1'b0);
      if (qv[3] !== 4'b0000 || qv[4] !== 4'b1001) begin
         $display("FAIL chain a=%b b=%b exp 0000/1001", qv[3], qv[4]); fails++;
      end
      checks++;
   endtask

   task automatic test_x_mode;
      step(1'b1, 1'b1, LOAD, 4'b0110, 4'b0011, 1'b0, 1'b0);
      step(1'b1, 1'b1, 3'bxxx, 4'b1111, 4'b1111, 1'b1, 1'b1);
      if (qv[0] !== 4'b0110 || cv[0] !== 1'b0) begin
         $display("FAIL x_mode q=%b c=%b exp 0110/0", qv[0], cv[0]); fails++;
      end
      checks++;
   endtask

   task automatic test_random;
      for (int n = 0; n < 300; n++) begin
         step($urandom_range(15) != 0, $urandom_range(3) != 0, 3'($urandom_range(7)),
              4'($urandom_range(15)), 4'($urandom_range(15)),
              1'($urandom_range(1)), 1'($urandom_range(1)));
         for (int i = 0; i < 5; i++) begin
            if (qv[i] !== 4'(mq[i]) || cv[i] !== 1'(mc[i]) || zv[i] !== (mq[i] == 0) ||
                slv[i] !== 1'(mq[i] / 8) || srv[i] !== 1'(mq[i] % 2)) begin
               $display("FAIL random[%0d] u%0d q=%b c=%b z=%b exp q=%0d c=%0d",
                        n, i, qv[i], cv[i], zv[i], mq[i], mc[i]); fails++;
            end
            checks++;
         end
      end
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; mode = 3'd0; d = '0; d2 = '0; sin_l = 1'b0; sin_r = 1'b0;
      @(negedge clk);
      test_reset;
      test_shift_rotate;
      test_wrap;
      test_saturate;
      test_hold_reset;
      test_chain;
      test_x_mode;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
